gol_sweep_ctrl: RTL and testbench

//  Generation sequencer and writer for the GoL row register file. Sweeps rows 0..ROWS-1 once per generation.
//  For each row it reads the three-row window (row_a/row/row_b), computes the next-state row, and writes it back in place.
//  Two shadow registers preserve already-overwritten old rows, so every generation is computed from a consistent old grid.

---
 rtl/gol_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_gol_sweep_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gol_sweep_ctrl.sv
// Generation sequencer/writer for the Game-of-Life row register file.
// Define GOL_TORUS_EN to wrap columns; otherwise off-grid columns read as dead.
module gol_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               start,
    input  logic               run,
    input  logic [WIDTH-1:0]   row_a,
    input  logic [WIDTH-1:0]   row,
    input  logic [WIDTH-1:0]   row_b,
    output logic [REGBITS-1:0] ra,
    output logic               regwrite,
    output logic [WIDTH-1:0]   wd,
    output logic               busy,
    output logic               done,
    output logic [15:0]        gen_count
);

    localparam int ROWS = 2**REGBITS;
    localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t             state_reg,    state_next;
    logic [REGBITS-1:0] row_idx_reg,  row_idx_next;
    logic [WIDTH-1:0]   nxt_reg,      nxt_next;
    logic [WIDTH-1:0]   prev_old_reg, prev_old_next;
    logic [WIDTH-1:0]   row0_old_reg, row0_old_next;
    logic [WIDTH-1:0]   cur_old_reg,  cur_old_next;
    logic [15:0]        gen_count_reg, gen_count_next;

    // Row 0's upper neighbour and row ROWS-1's lower neighbour come from old data:
    // row_a at row 0 is still unwritten, row_b at the last row was overwritten long ago.
    logic [WIDTH-1:0] above_sel, below_sel, life_next;

    assign above_sel = (row_idx_reg == '0)      ? row_a        : prev_old_reg;
    assign below_sel = (row_idx_reg == LAST_ROW) ? row0_old_reg : row_b;

    // Extended rows: bit 0 holds column -1, bit WIDTH+1 holds column WIDTH.
    logic [WIDTH+1:0] ext_a, ext_r, ext_b;

`ifdef GOL_TORUS_EN
    assign ext_a = {above_sel[0], above_sel, above_sel[WIDTH-1]};
    assign ext_r = {row[0],       row,       row[WIDTH-1]};
    assign ext_b = {below_sel[0], below_sel, below_sel[WIDTH-1]};
`else
    assign ext_a = {1'b0, above_sel, 1'b0};
    assign ext_r = {1'b0, row,       1'b0};
    assign ext_b = {1'b0, below_sel, 1'b0};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic [3:0] n;
            assign n = 4'(ext_a[gi]) + 4'(ext_a[gi+1]) + 4'(ext_a[gi+2])
                     + 4'(ext_r[gi])                   + 4'(ext_r[gi+2])
                     + 4'(ext_b[gi]) + 4'(ext_b[gi+1]) + 4'(ext_b[gi+2]);
            assign life_next[gi] = (n == 4'd3) | (row[gi] & (n == 4'd2));
        end
    endgenerate

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_reg     <= IDLE;
            row_idx_reg   <= '0;
            nxt_reg       <= '0;
            prev_old_reg  <= '0;
            row0_old_reg  <= '0;
            cur_old_reg   <= '0;
            gen_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            row_idx_reg   <= row_idx_next;
            nxt_reg       <= nxt_next;
            prev_old_reg  <= prev_old_next;
            row0_old_reg  <= row0_old_next;
            cur_old_reg   <= cur_old_next;
            gen_count_reg <= gen_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_idx_next   = row_idx_reg;
        nxt_next       = nxt_reg;
        prev_old_next  = prev_old_reg;
        row0_old_next  = row0_old_reg;
        cur_old_next   = cur_old_reg;
        gen_count_next = gen_count_reg;
        ra             = '0;
        regwrite       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    row_idx_next = '0;
                    state_next   = RD;
                end
            end
            RD: begin
                ra           = row_idx_reg;
                busy         = 1'b1;
                cur_old_next = row;
                if (row_idx_reg == '0) begin
                    row0_old_next = row;
                end
                nxt_next   = life_next;
                state_next = WR;
            end
            WR: begin
                ra            = row_idx_reg;
                regwrite      = 1'b1;
                busy          = 1'b1;
                prev_old_next = cur_old_reg;
                if (row_idx_reg == LAST_ROW) begin
                    state_next = FIN;
                end else begin
                    row_idx_next = row_idx_reg + REGBITS'(1);
                    state_next   = RD;
                end
            end
            FIN: begin
                done           = 1'b1;
                busy           = 1'b1;
                gen_count_next = gen_count_reg + 16'd1;
                if (run) begin
                    row_idx_next = '0;
                    state_next   = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wd        = nxt_reg;
    assign gen_count = gen_count_reg;

endmodule

// File: tb/tb_gol_sweep_ctrl.sv
// Bench for gol_sweep_ctrl: behavioural register file plus whole-grid Life model.
module tb_gol_sweep_ctrl;

    typedef logic [7:0][7:0] grid_t;

    logic       ph1 = 1'b0;
    logic       reset, start, run;
    logic [7:0] row_a, row, row_b, wd;
    logic [2:0] ra;
    logic       regwrite, busy, done;
    logic [15:0] gen_count;

    grid_t mem;
    grid_t load_grid;
    logic  load_en;

    int errors = 0;
    int checks = 0;
    int exp_gen = 0;

    always #5 ph1 = ~ph1;

    gol_sweep_ctrl #(.WIDTH(8), .REGBITS(3)) dut (
        .ph1(ph1), .reset(reset), .start(start), .run(run),
        .row_a(row_a), .row(row), .row_b(row_b),
        .ra(ra), .regwrite(regwrite), .wd(wd),
        .busy(busy), .done(done), .gen_count(gen_count)
    );

    assign row_a = mem[ra - 3'd1];
    assign row   = mem[ra];
    assign row_b = mem[ra + 3'd1];

    always @(posedge ph1) begin
        if (load_en) mem <= load_grid;
        else if (regwrite) mem[ra] <= wd;
    end

    function automatic grid_t life_ref(grid_t g);
        grid_t res;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        if (dr == 0 && dc == 0) continue;
                        rr = (r + dr + 8) % 8;
                        cc = c + dc;
`ifdef GOL_TORUS_EN
                        cc = (cc + 8) % 8;
`else
                        if (cc < 0 || cc > 7) continue;
`endif
                        n += int'(g[rr][cc]);
                    end
                end
                res[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input grid_t g);
        load_grid = g;
        load_en   = 1'b1;
        @(posedge ph1); #1;
        load_en   = 1'b0;
    endtask

    // One generation from IDLE; returns cycle of done (start edge = cycle 0).
    task automatic do_gen(output int cyc, output int wr, output int dn);
        start = 1'b1;
        @(posedge ph1); #1;
        start = 1'b0;
        cyc = 1; wr = 0; dn = 0;
        while (1) begin
            if (regwrite) wr++;
            if (done) begin dn++; break; end
            if (cyc > 100) begin
                chk("done_timeout", 64'(cyc), 64'd17);
                break;
            end
            @(posedge ph1); #1;
            cyc++;
        end
        @(posedge ph1); #1;
        exp_gen++;
        $display("gen: cycles=%0d writes=%0d done=%0d gen_count=%0d", cyc, wr, dn, gen_count);
    endtask

    initial begin
        grid_t g, e;
        int cyc, wr, dn;
        int d1, d2, dcount, c;

        reset = 1'b1; start = 1'b0; run = 1'b0;
        load_en = 1'b0; load_grid = '0;
        @(posedge ph1); @(posedge ph1); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_regwrite", 64'(regwrite), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ra", 64'(ra), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        reset = 1'b0;
        $display("reset: busy=%0d ra=%0d gen_count=%0d", busy, ra, gen_count);

        // Blinker
        g = '0; g[3] = 8'b00111000;
        load(g);
        do_gen(cyc, wr, dn);
        e = '0; e[2] = 8'b00010000; e[3] = 8'b00010000; e[4] = 8'b00010000;
        chk("blk_latency", 64'(cyc), 64'd17);
        chk("blk_writes", 64'(wr), 64'd8);
        chk("blk_done", 64'(dn), 64'd1);
        chk("blk_grid", mem, e);
        chk("blk_model", mem, life_ref(g));
        chk("blk_gen", 64'(gen_count), 64'(exp_gen));
        chk("blk_idle", 64'(busy), 64'd0);

        // Block straddling the vertical wrap
        g = '0; g[7] = 8'b00011000; g[0] = 8'b00011000;
        load(g);
        do_gen(cyc, wr, dn);
        chk("vwrap_grid", mem, g);

        // Column edge pattern
        g = '0; g[3] = 8'b11000001;
        load(g);
        do_gen(cyc, wr, dn);
        e = '0;
`ifdef GOL_TORUS_EN
        e[2] = 8'b10000000; e[3] = 8'b10000000; e[4] = 8'b10000000;
`endif
        chk("col_grid", mem, e);
        chk("col_model", mem, life_ref(g));

        // Chained run with a stray start while busy
        g = '0; g[3] = 8'b00111000;
        load(g);
        run = 1'b1; start = 1'b1;
        @(posedge ph1); #1;
        start = 1'b0;
        c = 1; d1 = 0; d2 = 0; dcount = 0;
        while (c < 80) begin
            start = (c == 20);
            if (done) begin
                dcount++;
                if (dcount == 1) d1 = c;
                else begin d2 = c; run = 1'b0; break; end
            end
            @(posedge ph1); #1;
            c++;
        end
        start = 1'b0;
        @(posedge ph1); #1;
        exp_gen += 2;
        $display("chain: done at %0d and %0d gen_count=%0d", d1, d2, gen_count);
        chk("chain_d1", 64'(d1), 64'd17);
        chk("chain_d2", 64'(d2), 64'd34);
        chk("chain_grid", mem, g);
        chk("chain_gen", 64'(gen_count), 64'(exp_gen));
        chk("chain_idle", 64'(busy), 64'd0);

        // Random grids against the model
        for (int k = 0; k < 8; k++) begin
            g = {$urandom(), $urandom()};
            load(g);
            do_gen(cyc, wr, dn);
            chk("rnd_grid", mem, life_ref(g));
            chk("rnd_latency", 64'(cyc), 64'd17);
            chk("rnd_gen", 64'(gen_count), 64'(exp_gen));
        end

        // Reset during WR of row 3
        g = {$urandom(), $urandom()};
        load(g);
        start = 1'b1;
        @(posedge ph1); #1;
        start = 1'b0;
        c = 0;
        while (!(ra == 3'd3 && regwrite)) begin
            if (c > 40) begin
                chk("mid_timeout", 64'(c), 64'd0);
                break;
            end
            @(posedge ph1); #1;
            c++;
        end
        reset = 1'b1;
        @(posedge ph1); #1;
        reset = 1'b0;
        exp_gen = 0;
        e = life_ref(g);
        for (int r = 4; r < 8; r++) e[r] = g[r];
        $display("midreset: busy=%0d regwrite=%0d ra=%0d gen_count=%0d", busy, regwrite, ra, gen_count);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_regwrite", 64'(regwrite), 64'd0);
        chk("mid_ra", 64'(ra), 64'd0);
        chk("mid_gen", 64'(gen_count), 64'd0);
        chk("mid_grid", mem, e);

        // Empty grid
        load('0);
        do_gen(cyc, wr, dn);
        chk("empty_grid", mem, 64'd0);
        chk("empty_done", 64'(dn), 64'd1);
        chk("empty_gen", 64'(gen_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
